// File: rtl/area_job_scheduler_pkg.sv
// Shared types and constants for the area job scheduler.
//   sched_state_t : scheduler FSM state encoding
//   RADIUS_W/AREA_W/ID_W : datapath and requester-index widths
//   cyc_next()    : cyclic successor of a requester index
package area_sched_pkg;

  localparam int unsigned RADIUS_W = 16;
  localparam int unsigned AREA_W   = 26;
  localparam int unsigned ID_W     = 3;
  localparam int unsigned CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  // (idx + 1) mod n, for idx < n
  function automatic logic [ID_W-1:0] cyc_next(input logic [ID_W-1:0] idx,
                                               input int unsigned     n);
    logic [ID_W-1:0] nxt;
    nxt = idx + ID_W'(1);
    if (32'(idx) + 32'd1 >= n) nxt = '0;
    return nxt;
  endfunction

endpackage

// File: rtl/area_job_scheduler_if.sv
// Bundle of all non-clock/reset signals of area_job_scheduler.
//   req_*      : per-requester valid/ready job intake, radius slice k at [16k+15:16k]
//   resp_*     : shared response bus (id, signed area, timeout error)
//   calc_*     : shared sphere-area datapath control and result
//   jobs_done  : completed non-error jobs (wrapping)
//   timeouts   : aborted jobs (saturating)
// master = scheduler view, slave = environment view.
interface area_job_scheduler_if
  import area_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) ();

  logic [N_REQ-1:0]          req_valid;
  logic [RADIUS_W*N_REQ-1:0] req_radius;
  logic [N_REQ-1:0]          req_ready;

  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic signed [AREA_W-1:0]  resp_area;
  logic                      resp_error;

  logic                      calc_en;
  logic [RADIUS_W-1:0]       calc_radius;
  logic signed [AREA_W-1:0]  calc_area;
  logic                      calc_rdy;

  logic [15:0]               jobs_done;
  logic [7:0]                timeouts;

  modport master (
    input  req_valid, req_radius, resp_ready, calc_area, calc_rdy,
    output req_ready, resp_valid, resp_id, resp_area, resp_error,
           calc_en, calc_radius, jobs_done, timeouts
  );

  modport slave (
    output req_valid, req_radius, resp_ready, calc_area, calc_rdy,
    input  req_ready, resp_valid, resp_id, resp_area, resp_error,
           calc_en, calc_radius, jobs_done, timeouts
  );

endinterface

// File: rtl/area_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : request vector
//   ptr    : highest-priority index (owned by the caller)
//   gnt    : one-hot grant of the first request at or after ptr, cyclically
//   gnt_id : encoded grant index
//   any    : at least one request present
module rr_arbiter
  import area_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any
);

  // Two linear passes (indices >= ptr, then < ptr) give the cyclic search
  // without any modulo arithmetic on the index.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!any && k >= 32'(ptr) && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        gnt_id = ID_W'(k);
      end
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!any && k < 32'(ptr) && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        gnt_id = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/area_job_scheduler.sv
// Round-robin scheduler sharing one sphere-area datapath among N_REQ
// requesters. Accepts one radius per job, holds calc_en/calc_radius steady
// while the datapath works, returns the result tagged with the requester id,
// and turns a missing calc_rdy into an error response after TIMEOUT cycles.
//   clk, rst : clock, synchronous active-high reset
//   bus      : area_job_scheduler_if master (requests, response, datapath, stats)
module area_job_scheduler
  import area_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst,
  area_job_scheduler_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  sched_state_t             state_q, state_d;
  logic [ID_W-1:0]          ptr_q, ptr_d;
  logic [ID_W-1:0]          id_q, id_d;
  logic [RADIUS_W-1:0]      radius_q, radius_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [AREA_W-1:0] area_q, area_d;
  logic                     err_q, err_d;
  logic                     rv_q, rv_d;
  logic                     en_q, en_d;
  logic [15:0]              done_q, done_d;
  logic [7:0]               to_q, to_d;

  logic [N_REQ-1:0]         gnt;
  logic [ID_W-1:0]          gnt_id;
  logic                     gnt_any;
  logic [RADIUS_W-1:0]      sel_radius;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  always_comb begin
    sel_radius = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt[k]) sel_radius = bus.req_radius[k*RADIUS_W +: RADIUS_W];
    end
  end

  // Accept strobe is the only combinational output; masked during reset so
  // no requester sees an accept that the reset then discards.
  assign bus.req_ready = (state_q == IDLE && !rst) ? gnt : '0;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    radius_d = radius_q;
    cnt_d    = cnt_q;
    area_d   = area_q;
    err_d    = err_q;
    rv_d     = rv_q;
    en_d     = en_q;
    done_d   = done_q;
    to_d     = to_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          radius_d = sel_radius;
          id_d     = gnt_id;
          cnt_d    = '0;
          ptr_d    = cyc_next(gnt_id, N_REQ);
          en_d     = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // calc_rdy takes precedence over a coincident timeout
        if (bus.calc_rdy) begin
          area_d  = bus.calc_area;
          err_d   = 1'b0;
          en_d    = 1'b0;
          rv_d    = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          area_d  = '0;
          err_d   = 1'b1;
          en_d    = 1'b0;
          rv_d    = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
          if (err_q) begin
            if (to_q != 8'hFF) to_d = to_q + 8'd1;
          end else begin
            done_d = done_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        rv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      radius_q <= '0;
      cnt_q    <= '0;
      area_q   <= '0;
      err_q    <= 1'b0;
      rv_q     <= 1'b0;
      en_q     <= 1'b0;
      done_q   <= '0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      radius_q <= radius_d;
      cnt_q    <= cnt_d;
      area_q   <= area_d;
      err_q    <= err_d;
      rv_q     <= rv_d;
      en_q     <= en_d;
      done_q   <= done_d;
      to_q     <= to_d;
    end
  end

  assign bus.resp_valid  = rv_q;
  assign bus.resp_id     = id_q;
  assign bus.resp_area   = area_q;
  assign bus.resp_error  = err_q;
  assign bus.calc_en     = en_q;
  assign bus.calc_radius = radius_q;
  assign bus.jobs_done   = done_q;
  assign bus.timeouts    = to_q;

endmodule

// File: tb/tb_area_job_scheduler.sv
// Directed self-checking bench for area_job_scheduler (N_REQ=4, TIMEOUT=16).
// Stub datapath: pulses calc_rdy once after calc_en has been high 12 cycles,
// returning {10'b0, radius}; stray_rdy injects rdy pulses with a marker area.
module tb_area_job_scheduler;
  import area_sched_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  area_job_scheduler_if #(.N_REQ(4)) bus ();

  area_job_scheduler #(.N_REQ(4), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic        stub_on;
  logic        stray_rdy;
  int unsigned en_cnt;

  always @(posedge clk) begin
    if (rst || !bus.calc_en) en_cnt <= 0;
    else                     en_cnt <= en_cnt + 1;
  end

  assign bus.calc_rdy  = (stub_on && bus.calc_en && en_cnt == 12) || stray_rdy;
  assign bus.calc_area = stray_rdy ? 26'h2AAAAAA : {10'b0, bus.calc_radius};

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_resp(input int unsigned start, input int unsigned limit,
                           output int unsigned n);
    n = start;
    while (bus.resp_valid !== 1'b1 && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_req_ready"},   32'(bus.req_ready),   32'h0);
    chk({p, "_resp_valid"},  32'(bus.resp_valid),  32'h0);
    chk({p, "_resp_id"},     32'(bus.resp_id),     32'h0);
    chk({p, "_resp_area"},   32'(bus.resp_area),   32'h0);
    chk({p, "_resp_error"},  32'(bus.resp_error),  32'h0);
    chk({p, "_calc_en"},     32'(bus.calc_en),     32'h0);
    chk({p, "_calc_radius"}, 32'(bus.calc_radius), 32'h0);
    chk({p, "_jobs_done"},   32'(bus.jobs_done),   32'h0);
    chk({p, "_timeouts"},    32'(bus.timeouts),    32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, got, cyc, last_t, seen;
    logic [2:0]  exp_ids [5];
    logic [15:0] radii [4];
    exp_ids = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    radii   = '{16'd10, 16'd20, 16'd30, 16'd40};

    rst = 1'b1; stub_on = 1'b1; stray_rdy = 1'b0;
    bus.req_valid = '0; bus.req_radius = '0; bus.resp_ready = 1'b0;
    step(); step();
    chk_zero("reset");
    rst = 1'b0;
    step();

    // Single job from requester 2
    bus.req_radius = {16'h0404, 16'h1234, 16'h0202, 16'h0101};
    bus.resp_ready = 1'b1;
    bus.req_valid  = 4'b0100;
    #1;
    chk("single_gnt", 32'(bus.req_ready), 32'h4);
    step();
    bus.req_valid = '0;
    chk("single_en",  32'(bus.calc_en), 32'h1);
    chk("single_rad", 32'(bus.calc_radius), 32'h1234);
    chk("single_rdy_run", 32'(bus.req_ready), 32'h0);
    wait_resp(1, 60, n);
    chk("single_lat",  n, 32'd14);
    chk("single_id",   32'(bus.resp_id), 32'd2);
    chk("single_area", 32'(bus.resp_area), 32'h1234);
    chk("single_err",  32'(bus.resp_error), 32'h0);
    chk("single_en_resp", 32'(bus.calc_en), 32'h0);
    step();
    chk("single_done", 32'(bus.jobs_done), 32'd1);
    chk("single_idle", 32'(bus.resp_valid), 32'h0);

    // Stray calc_rdy in IDLE
    stray_rdy = 1'b1;
    step();
    stray_rdy = 1'b0;
    chk("stray_idle_rv",   32'(bus.resp_valid), 32'h0);
    chk("stray_idle_en",   32'(bus.calc_en),    32'h0);
    chk("stray_idle_done", 32'(bus.jobs_done),  32'd1);
    chk("stray_idle_to",   32'(bus.timeouts),   32'd0);

    // Fairness after reset (ptr back to 0)
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_done", 32'(bus.jobs_done), 32'd0);
    bus.req_radius = {16'd40, 16'd30, 16'd20, 16'd10};
    bus.req_valid  = 4'b1111;
    got = 0; cyc = 0; last_t = 0;
    while (got < 5 && cyc < 200) begin
      step();
      cyc++;
      if (bus.req_ready != '0) chk("fair_en_gap", 32'(bus.calc_en), 32'h0);
      if (bus.resp_valid) begin
        chk("fair_id",   32'(bus.resp_id),   32'(exp_ids[got]));
        chk("fair_area", 32'(bus.resp_area), 32'(radii[exp_ids[got]]));
        chk("fair_err",  32'(bus.resp_error), 32'h0);
        if (got > 0) chk("fair_period", cyc - last_t, 32'd15);
        last_t = cyc;
        got++;
        if (got == 5) bus.req_valid = '0;
      end
    end
    chk("fair_count", got, 32'd5);
    step();
    chk("fair_done", 32'(bus.jobs_done), 32'd5);

    // Backpressure (ptr=1, only requester 0 asks)
    bus.resp_ready = 1'b0;
    bus.req_valid  = 4'b0001;
    #1;
    chk("bp_gnt", 32'(bus.req_ready), 32'h1);
    step();
    wait_resp(1, 60, n);
    chk("bp_lat", n, 32'd14);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) stray_rdy = 1'b1;
      step();
      stray_rdy = 1'b0;
      chk("bp_rv",   32'(bus.resp_valid), 32'h1);
      chk("bp_id",   32'(bus.resp_id),    32'd0);
      chk("bp_area", 32'(bus.resp_area),  32'd10);
      chk("bp_err",  32'(bus.resp_error), 32'h0);
      chk("bp_en",   32'(bus.calc_en),    32'h0);
      chk("bp_rdy",  32'(bus.req_ready),  32'h0);
    end
    chk("bp_done_hold", 32'(bus.jobs_done), 32'd5);
    bus.resp_ready = 1'b1;
    step();
    chk("bp_release_rv",  32'(bus.resp_valid), 32'h0);
    chk("bp_release_done", 32'(bus.jobs_done), 32'd6);
    chk("bp_regrant",     32'(bus.req_ready),  32'h1);
    step();
    bus.req_valid = '0;
    wait_resp(1, 60, n);
    chk("bp2_lat",  n, 32'd14);
    chk("bp2_area", 32'(bus.resp_area), 32'd10);
    step();
    chk("bp2_done", 32'(bus.jobs_done), 32'd7);

    // Timeout (ptr=1, requester 3)
    stub_on = 1'b0;
    bus.req_valid = 4'b1000;
    #1;
    chk("to_gnt", 32'(bus.req_ready), 32'h8);
    step();
    bus.req_valid = '0;
    wait_resp(1, 60, n);
    chk("to_lat",  n, 32'd17);
    chk("to_id",   32'(bus.resp_id),    32'd3);
    chk("to_err",  32'(bus.resp_error), 32'h1);
    chk("to_area", 32'(bus.resp_area),  32'h0);
    step();
    chk("to_count1", 32'(bus.timeouts),  32'd1);
    chk("to_done",   32'(bus.jobs_done), 32'd7);
    bus.req_valid = 4'b1000;
    got = 1; cyc = 0;
    while (got < 300 && cyc < 8000) begin
      step();
      cyc++;
      if (bus.resp_valid) begin
        got++;
        if (got == 300) bus.req_valid = '0;
      end
    end
    chk("to_jobs", got, 32'd300);
    step();
    chk("to_sat",       32'(bus.timeouts),  32'd255);
    chk("to_sat_done",  32'(bus.jobs_done), 32'd7);

    // Mid-job reset at RUN cycle 5 (ptr=0, requester 1 -> ptr 2)
    stub_on = 1'b1;
    bus.req_valid = 4'b0010;
    #1;
    chk("mr_gnt", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid = '0;
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("midrst");
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.resp_valid) seen++;
    end
    chk("mr_no_resp", seen, 32'd0);
    bus.req_valid = 4'b1001;
    #1;
    chk("mr_ptr0", 32'(bus.req_ready), 32'h1);
    step();
    wait_resp(1, 60, n);
    chk("mr_lat0",  n, 32'd14);
    chk("mr_id0",   32'(bus.resp_id),   32'd0);
    chk("mr_area0", 32'(bus.resp_area), 32'd10);
    step();
    chk("mr_gnt3", 32'(bus.req_ready), 32'h8);
    step();
    bus.req_valid = '0;
    wait_resp(1, 60, n);
    chk("mr_lat3",  n, 32'd14);
    chk("mr_id3",   32'(bus.resp_id),   32'd3);
    chk("mr_area3", 32'(bus.resp_area), 32'd40);
    step();
    chk("mr_done", 32'(bus.jobs_done), 32'd2);
    chk("mr_to",   32'(bus.timeouts),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/area_job_scheduler.md
# area_job_scheduler

Round-robin scheduler that shares one sphere-area pipeline (radius in, signed area out, `en`/`rdy` controlled) among `N_REQ` requesters. It accepts one radius per job over a valid/ready handshake and holds the pipeline's `en` and radius stable for the whole computation. It returns the result with the requester ID on a shared response bus and converts a missing `rdy` into an error response after a timeout. It sits between the per-channel control logic and the single area datapath instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 64: cycles in RUN without `calc_rdy` before abort, 8..255.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `req_valid`  in  N_REQ  per-requester job request.
- `req_radius`  in  16*N_REQ  unsigned radius; slice k = bits [16k+15:16k].
- `req_ready`  out  N_REQ  one-hot accept strobe.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  response consumed.
- `resp_id`  out  3  requester index of the response.
- `resp_area`  out  26  signed area result; 0 on error.
- `resp_error`  out  1  job aborted by timeout.
- `calc_en`  out  1  datapath enable.
- `calc_radius`  out  16  datapath radius input.
- `calc_area`  in  26  signed datapath result.
- `calc_rdy`  in  1  datapath result-valid strobe.
- `jobs_done`  out  16  completed non-error jobs; wraps at 65535→0.
- `timeouts`  out  8  aborted jobs; saturates at 255.

## Operation
- FSM states: IDLE, RUN, RESP.
- **IDLE**
  - `calc_en`=0. This guarantees at least one cycle of `en` low between jobs, which clears the datapath enable-delay chain.
  - If any `req_valid` is high, grant the first asserted index at or after `ptr`, searching cyclically.
  - On grant k: assert `req_ready[k]` combinationally in the same cycle, latch radius slice k and id k, clear the cycle counter, advance `ptr` to (k+1) mod N_REQ, and go to RUN.
- **RUN**
  - `calc_en`=1 and `calc_radius` = latched radius, both constant for the whole state. The counter increments each cycle.
  - On `calc_rdy`=1: capture `calc_area`, set `resp_error`=0, and go to RESP. Only the first `calc_rdy` is used.
  - Else if counter == TIMEOUT-1: set area 0, `resp_error`=1, and go to RESP.
  - If `calc_rdy` and timeout occur in the same cycle, `calc_rdy` wins.
- **RESP**
  - `calc_en`=0. `resp_valid`=1 with `resp_id`/`resp_area`/`resp_error` held stable.
  - When `resp_ready`=1: pulse-increment `jobs_done` (non-error) or `timeouts` (error, saturating), then go to IDLE.
- `req_ready` is 0 outside IDLE. `req_valid` on non-granted requesters is left pending, with no loss.
- `calc_rdy` outside RUN is ignored.
- Reset, including mid-job: state = IDLE and `ptr`=0. All outputs are 0: `req_ready`, `resp_*`, `calc_en`, `calc_radius`, and both counters. No response is issued for an aborted job.

## Timing
- Grant cycle T: `req_ready[k]`=1. From T+1: `calc_en`=1 with `calc_radius` valid.
- `calc_rdy` seen at cycle R gives `resp_valid`=1 at R+1.
- `resp_ready` high at cycle A gives IDLE at A+1; a new grant is possible at A+1, with `calc_en` rising at A+2.
- Back-to-back throughput: one job per (datapath latency + 3) cycles when `resp_ready` is held high.
- Timeout: `resp_valid` rises exactly TIMEOUT+1 cycles after the grant cycle.
- All outputs except `req_ready` are registered.

## Structure
- Package `area_sched_pkg`:
  - state enum `sched_state_t` {IDLE, RUN, RESP};
  - `RADIUS_W`=16, `AREA_W`=26, `ID_W`=3;
  - function for cyclic next-index.
- Sub-module `rr_arbiter`, parameterised on N_REQ:
  - inputs `req` and `ptr`;
  - outputs one-hot `gnt`, encoded `gnt_id`, `any`;
  - purely combinational. `ptr` is owned by the scheduler.
- Top module holds FSM, latches, counters, response registers.

## Test plan
Bench stub datapath: after `en` has been high for 12 cycles it pulses `rdy` once with `calc_area` = {10'b0, radius}.
- Single job: `req_valid[2]`=1, radius 0x1234, `resp_ready`=1 → `resp_valid` 14 cycles after grant, `resp_id`=2, `resp_area`=0x1234, `resp_error`=0, `jobs_done`=1.
- Fairness: all 4 requesters valid continuously, radii 10/20/30/40 → responses in id order 0,1,2,3,0…, areas matching, `calc_en` low ≥1 cycle between jobs.
- Backpressure: `resp_ready`=0 for 20 cycles after `resp_valid` → outputs stable, no new `req_ready`, `calc_en`=0; releasing it returns to IDLE next cycle.
- Timeout: stub never pulses `rdy`, TIMEOUT=16 → `resp_valid` 17 cycles after grant, `resp_error`=1, `resp_area`=0, `timeouts`=1. After 300 such jobs, `timeouts`=255.
- Mid-job reset: `rst` 1 cycle at RUN cycle 5 → next cycle all outputs 0, no response. A later request from requester 3 is granted with `ptr` restarted at 0.
- Stray `calc_rdy`: `calc_rdy` pulsed in IDLE and RESP → ignored, no counter change, no state change.
